// File: rtl/data_stack_if.sv
// Operand/result bus between the data stack and its user (decoder + ALU).
// The stack takes the slave side; whatever issues ops takes the master side.
interface data_stack_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) ();
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_din;
    logic [WIDTH-1:0] o_tos;
    logic [WIDTH-1:0] o_nos;
    logic [AW:0]      o_count;
    logic             o_empty;
    logic             o_full;
    logic             o_err;
    logic [1:0]       o_err_code;

    modport master (
        output i_op, i_din,
        input  o_tos, o_nos, o_count, o_empty, o_full, o_err, o_err_code
    );

    modport slave (
        input  i_op, i_din,
        output o_tos, o_nos, o_count, o_empty, o_full, o_err, o_err_code
    );
endinterface

// File: rtl/data_stack.sv
// Data stack feeding the ALU: TOS/NOS out, result written back in one cycle.
// Define DSTACK_ERR_TRAP_EN to get the sticky err/err_code trap; otherwise both read 0.
module data_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         reset,
    data_stack_if.slave  bus
);

    localparam logic [2:0] OP_NOP     = 3'b000;
    localparam logic [2:0] OP_PUSH    = 3'b001;
    localparam logic [2:0] OP_POP     = 3'b010;
    localparam logic [2:0] OP_REPLACE = 3'b011;
    localparam logic [2:0] OP_BINOP   = 3'b100;
    localparam logic [2:0] OP_DUP     = 3'b101;
    localparam logic [2:0] OP_SWAP    = 3'b110;

    localparam logic [AW-1:0] IDX_ONE   = 1;
    localparam logic [AW:0]   CNT_ONE   = 1;
    localparam logic [AW:0]   CNT_TWO   = 2;
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_count;

    logic [AW-1:0]    w_top;
    logic [AW-1:0]    w_next;
    logic [AW-1:0]    w_free;
    logic             w_hasOne;
    logic             w_hasTwo;
    logic             w_full;
    logic [WIDTH-1:0] w_tos;
    logic [WIDTH-1:0] w_nos;
    logic             w_ovf;
    logic             w_unf;
    logic             w_legal;

    assign w_top    = r_count[AW-1:0] - IDX_ONE;
    assign w_next   = w_top - IDX_ONE;
    assign w_free   = r_count[AW-1:0];
    assign w_hasOne = (r_count >= CNT_ONE);
    assign w_hasTwo = (r_count >= CNT_TWO);
    assign w_full   = (r_count == CNT_DEPTH);
    assign w_tos    = w_hasOne ? r_mem[w_top]  : '0;
    assign w_nos    = w_hasTwo ? r_mem[w_next] : '0;

    // A DUP on an empty stack has nothing to copy, so it is classed as underflow.
    always_comb begin
        w_ovf = 1'b0;
        w_unf = 1'b0;
        case (bus.i_op)
            OP_PUSH:    w_ovf = w_full;
            OP_POP:     w_unf = !w_hasOne;
            OP_REPLACE: w_unf = !w_hasOne;
            OP_BINOP:   w_unf = !w_hasTwo;
            OP_DUP: begin
                w_ovf = w_full;
                w_unf = !w_hasOne;
            end
            OP_SWAP:    w_unf = !w_hasTwo;
            default: begin
                w_ovf = 1'b0;
                w_unf = 1'b0;
            end
        endcase
        w_legal = !(w_ovf || w_unf);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_legal) begin
            case (bus.i_op)
                OP_PUSH, OP_DUP:  r_count <= r_count + CNT_ONE;
                OP_POP, OP_BINOP: r_count <= r_count - CNT_ONE;
                default:          r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (!reset && w_legal) begin
            case (bus.i_op)
                OP_PUSH:    r_mem[w_free] <= bus.i_din;
                OP_REPLACE: r_mem[w_top]  <= bus.i_din;
                OP_BINOP:   r_mem[w_next] <= bus.i_din;
                OP_DUP:     r_mem[w_free] <= w_tos;
                OP_SWAP: begin
                    r_mem[w_top]  <= r_mem[w_next];
                    r_mem[w_next] <= r_mem[w_top];
                end
                default: ;
            endcase
        end
    end

    assign bus.o_tos   = w_tos;
    assign bus.o_nos   = w_nos;
    assign bus.o_count = r_count;
    assign bus.o_empty = !w_hasOne;
    assign bus.o_full  = w_full;

`ifdef DSTACK_ERR_TRAP_EN
    logic       r_err;
    logic [1:0] r_errCode;

    // The first error type is kept until reset; later faults only keep err high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err     <= 1'b0;
            r_errCode <= 2'b00;
        end else if (!w_legal) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_errCode <= w_ovf ? 2'b01 : 2'b10;
            end
        end
    end

    assign bus.o_err      = r_err;
    assign bus.o_err_code = r_errCode;
`else
    assign bus.o_err      = 1'b0;
    assign bus.o_err_code = 2'b00;
`endif

endmodule
